ag_me_skid: RTL and testbench

- Consumer-side reader of the AG pipeline latch.
- Accepts the packed 341-bit AG bundle (valid in bit 0) and buffers it in a 2-entry skid queue.
- Presents the oldest entry to the ME stage.
- Drives the AG latch stall from a flop, so the ME-stage stall never combinationally reaches AG.
- Supports a full pipeline flush and counts backpressure cycles for performance analysis.

---
 rtl/ag_pkg.sv | 54 +++++
 rtl/ag_skid_slot.sv | 25 ++
 rtl/ag_me_skid.sv | 117 +++++++++++
 tb/tb_ag_me_skid.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ag_pkg.sv
// Shared AG pipeline definitions: bundle width, field positions and the
// occupancy encoding used by the AG->ME skid buffer.
package ag_pkg;

    localparam int AG_W        = 341;
    localparam int STALL_CNT_W = 16;

    // Field positions inside the packed AG bundle (msb/lsb pairs)
    localparam int CS_MSB         = 340;
    localparam int CS_LSB         = 290;
    localparam int ADDR1_MSB      = 289;
    localparam int ADDR1_LSB      = 258;
    localparam int ADDR2_MSB      = 257;
    localparam int ADDR2_LSB      = 226;
    localparam int SRC1_MSB       = 225;
    localparam int SRC1_LSB       = 194;
    localparam int SRC2_MSB       = 193;
    localparam int SRC2_LSB       = 162;
    localparam int NEIP_MSB       = 161;
    localparam int NEIP_LSB       = 130;
    localparam int EIP_MSB        = 129;
    localparam int EIP_LSB        = 98;
    localparam int BP_TGT_MSB     = 97;
    localparam int BP_TGT_LSB     = 66;
    localparam int SEGRC1_MSB     = 65;
    localparam int SEGRC1_LSB     = 50;
    localparam int LIMIT_MSB      = 49;
    localparam int LIMIT_LSB      = 30;
    localparam int IMM8_MSB       = 29;
    localparam int IMM8_LSB       = 22;
    localparam int SEGR1_MSB      = 21;
    localparam int SEGR1_LSB      = 19;
    localparam int OPSIZE_MSB     = 18;
    localparam int OPSIZE_LSB     = 17;
    localparam int DR1_MSB        = 16;
    localparam int DR1_LSB        = 14;
    localparam int DR2_MSB        = 13;
    localparam int DR2_LSB        = 11;
    localparam int DRSEG_MSB      = 10;
    localparam int DRSEG_LSB      = 8;
    localparam int BP_TAKEN_BIT   = 7;
    localparam int INDIR_BIT      = 6;
    localparam int DFLAG_BIT      = 5;
    localparam int BR_FETCHID_MSB = 4;
    localparam int BR_FETCHID_LSB = 1;
    localparam int V_BIT          = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/ag_skid_slot.sv
// One W-bit storage slot of the skid buffer: load-enabled register that
// clears asynchronously on reset.
module ag_skid_slot #(
    parameter int W = 341
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
        end else if (en) begin
            data_reg <= d;
        end
    end

    assign q = data_reg;

endmodule

// File: rtl/ag_me_skid.sv
// AG->ME consumer-side skid buffer: two-entry queue (head + skid) with a
// registered stall back to the AG latch, flush, and a stall-cycle counter.
module ag_me_skid
    import ag_pkg::*;
#(
    parameter int W     = AG_W,
    parameter int CNT_W = STALL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     i_bundle,
    output logic             o_ag_stall,
    input  logic             i_me_stall,
    input  logic             i_flush,
    output logic [W-1:0]     o_bundle,
    output logic             o_v,
    output logic [1:0]       o_occ,
    output logic [CNT_W-1:0] o_stall_cnt
);

    occ_e             state_reg, state_next;
    logic             stall_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic             push, pop;
    logic             head_en, head_from_skid, skid_en;
    logic [W-1:0]     head_q, skid_q, head_d;

    // While stalled the AG latch re-presents the same op; ignoring it avoids a duplicate
    assign push = i_bundle[V_BIT] & ~stall_reg & ~i_flush;
    assign pop  = o_v & ~i_me_stall & ~i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= OCC_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        head_en        = 1'b0;
        head_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (i_flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state_reg)
                OCC_EMPTY: begin
                    if (push) begin
                        head_en    = 1'b1;
                        state_next = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_en = 1'b1;
                    end else if (push) begin
                        skid_en    = 1'b1;
                        state_next = OCC_TWO;
                    end else if (pop) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_en        = 1'b1;
                        head_from_skid = 1'b1;
                        state_next     = OCC_ONE;
                    end
                end
                default: begin
                    state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : i_bundle;

    ag_skid_slot #(.W(W)) u_head (
        .clk (clk),
        .rst (rst),
        .en  (head_en),
        .d   (head_d),
        .q   (head_q)
    );

    ag_skid_slot #(.W(W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (i_bundle),
        .q   (skid_q)
    );

    // Stall is a flop so ME-side backpressure never forms a combinational path into AG
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg     <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            stall_reg <= (state_next == OCC_TWO);
            if (stall_reg && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign o_ag_stall  = stall_reg;
    assign o_bundle    = head_q;
    assign o_v         = (state_reg != OCC_EMPTY);
    assign o_occ       = state_reg;
    assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ag_me_skid.sv
// Self-checking bench for ag_me_skid: directed steps plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_ag_me_skid;

    localparam int W = 341;

    logic          clk;
    logic          rst;
    logic [W-1:0]  i_bundle;
    logic          o_ag_stall;
    logic          i_me_stall;
    logic          i_flush;
    logic [W-1:0]  o_bundle;
    logic          o_v;
    logic [1:0]    o_occ;
    logic [15:0]   o_stall_cnt;

    ag_me_skid dut (
        .clk         (clk),
        .rst         (rst),
        .i_bundle    (i_bundle),
        .o_ag_stall  (o_ag_stall),
        .i_me_stall  (i_me_stall),
        .i_flush     (i_flush),
        .o_bundle    (o_bundle),
        .o_v         (o_v),
        .o_occ       (o_occ),
        .o_stall_cnt (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, the stall the DUT should present, stall count
    logic [W-1:0] mq[$];
    logic         m_stall;
    logic [15:0]  m_cnt;

    function automatic logic [W-1:0] rand_bundle(input logic valid);
        logic [351:0] r;
        for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
        r[0] = valid;
        return r[W-1:0];
    endfunction

    task automatic chk1(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp_v[63:0]);
        end
    endtask

    task automatic check_all();
        chk1("occ",   W'(o_occ),       W'(mq.size()));
        chk1("v",     W'(o_v),         W'(mq.size() != 0));
        chk1("stall", W'(o_ag_stall),  W'(m_stall));
        chk1("cnt",   W'(o_stall_cnt), W'(m_cnt));
        if (mq.size() != 0) chk1("bundle", o_bundle, mq[0]);
    endtask

    task automatic model_reset();
        mq.delete();
        m_stall = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic step(input logic [W-1:0] b, input logic ms, input logic fl);
        logic push, pop;
        i_bundle   = b;
        i_me_stall = ms;
        i_flush    = fl;
        @(posedge clk);
        push = b[0] && !m_stall && !fl;
        pop  = (mq.size() != 0) && !ms && !fl;
        if (m_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(b);
        end
        m_stall = (mq.size() == 2);
        #1;
        check_all();
    endtask

    initial begin
        logic [W-1:0] a, b, c, f, idle;
        logic [W-1:0] stream[8];
        logic [31:0]  eip;

        idle       = '0;
        i_bundle   = '0;
        i_me_stall = 1'b0;
        i_flush    = 1'b0;
        rst        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk1("rst_bundle", o_bundle, '0);
        @(negedge clk);
        rst = 1'b1;

        // Single op, 1-cycle latency, EIP field intact
        a = rand_bundle(1'b1);
        a[129:98] = 32'h0000_1000;
        step(a, 1'b0, 1'b0);
        eip = o_bundle[129:98];
        chk1("eip", W'(eip), W'(32'h0000_1000));
        step(idle, 1'b0, 1'b0);

        // Fill under ME stall, held C ignored, then drain preserving A,B,C
        a = rand_bundle(1'b1);
        b = rand_bundle(1'b1);
        c = rand_bundle(1'b1);
        step(a, 1'b1, 1'b0);
        step(b, 1'b1, 1'b0);
        chk1("full_head_a", o_bundle, a);
        step(c, 1'b1, 1'b0);
        step(c, 1'b1, 1'b0);
        chk1("full_occ", W'(o_occ), W'(2));
        step(c, 1'b0, 1'b0);
        chk1("head_b", o_bundle, b);
        step(c, 1'b0, 1'b0);
        chk1("head_c", o_bundle, c);
        step(idle, 1'b0, 1'b0);
        $display("dir fill/drain done occ=%0d", o_occ);

        // Streaming: one pop per cycle, no stall
        for (int i = 0; i < 8; i++) begin
            stream[i] = rand_bundle(1'b1);
            step(stream[i], 1'b0, 1'b0);
            chk1("stream_data", o_bundle, stream[i]);
            chk1("stream_nostall", W'(o_ag_stall), W'(0));
        end
        step(idle, 1'b0, 1'b0);

        // Flush from TWO with a valid input present
        f = rand_bundle(1'b1);
        step(a, 1'b1, 1'b0);
        step(b, 1'b1, 1'b0);
        step(f, 1'b1, 1'b1);
        chk1("flush_v", W'(o_v), W'(0));
        step(idle, 1'b0, 1'b0);
        chk1("flush_gone", W'(o_v), W'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(rand_bundle(1'($urandom_range(0, 3) != 0)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 19) == 0));
            $display("rnd %0d occ=%0d v=%0b stall=%0b", i, o_occ, o_v, o_ag_stall);
        end
        step(idle, 1'b0, 1'b1);

        // Counter saturation
        step(a, 1'b1, 1'b0);
        step(b, 1'b1, 1'b0);
        for (int i = 0; i < 65600; i++) step(idle, 1'b1, 1'b0);
        chk1("cnt_sat", W'(o_stall_cnt), W'(16'hFFFF));
        $display("sat cnt=%0h", o_stall_cnt);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk1("arst_bundle", o_bundle, '0);
        chk1("arst_cnt", W'(o_stall_cnt), W'(0));
        @(negedge clk);
        rst = 1'b1;
        step(idle, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
